aes_key_sched_ctrl: RTL and testbench
=====================================

# aes_key_sched_ctrl

Sequencer that drives the combinational `key_expansion` round function to build the complete AES-128 key schedule. It accepts a cipher key over a valid/ready handshake and produces one round key per clock for 10 cycles. The 11 round keys are held in an internal register bank. The cipher datapath reads them by index, so encryption rounds can consume keys in any order once the schedule is marked valid.

## Interface
Parameters:
- `NR`, default 10: number of AES rounds; round keys stored = `NR+1`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `key_valid`, in, 1: cipher key present on `key_in`.
- `key_in`, in, 128: cipher key, byte 0 in bits [127:120].
- `key_ready`, out, 1: block can accept a key.
- `busy`, out, 1: expansion in progress.
- `keys_valid`, out, 1: all `NR+1` round keys are stored and stable.
- `rk_idx`, in, 4: round-key read index, 0..`NR`.
- `rk_out`, out, 128: round key at `rk_idx`, combinational read.

## Operation
- FSM states: `IDLE`, `EXPAND`, `READY`.
- `key_ready = (state != EXPAND)`.
- `busy = (state == EXPAND)`.
- Key accept: a key is accepted on a clock edge where `key_valid && key_ready`. On that edge:
  - `rk[0] <= key_in`
  - `round_cnt <= 0`
  - `keys_valid <= 0`
  - state goes to `EXPAND`
- EXPAND: `key_expansion` is driven with `num_round = round_cnt` and `key = rk[round_cnt]`. Each edge:
  - `rk[round_cnt+1] <= key_out`
  - `round_cnt <= round_cnt + 1`
- EXPAND exit: the edge that writes `rk[NR]` (when `round_cnt == NR-1`) moves the state to `READY` and sets `keys_valid <= 1`.
- READY: the bank holds its contents. A new accepted key restarts the sequence exactly as from IDLE; `keys_valid` drops on the accept edge.
- `key_valid` during EXPAND is ignored. No acceptance occurs, and the requester must hold the key until `key_ready` is high.
- Reads:
  - `rk_out = rk[rk_idx]` for `rk_idx <= NR`.
  - `rk_out = 0` for `rk_idx > NR`.
  - Reads are legal in any state. Data is only guaranteed when `keys_valid` is high.
- `round_cnt` is 4 bits and never exceeds `NR-1` while in EXPAND; there is no wrap-around.

## Timing
- Reset (with `rst_n` low at an edge):
  - state = `IDLE`, `round_cnt = 0`
  - `keys_valid = 0`, `busy = 0`, `key_ready = 1`
  - all `rk[*] = 0`, so `rk_out = 0`
- Latency: with the accept at edge E0, `rk[0]` is valid after E0 and `rk[n]` is valid after E(n). `keys_valid` is high after E10, so keys are usable 10 cycles after acceptance.
- Throughput: one key schedule per 11 cycles when keys are presented back-to-back. A key can be accepted on the edge immediately after entering READY.
- Reset mid-EXPAND: aborts the sequence at the next edge and clears all state as above. Partial keys are not retained.
- Simultaneous accept and read in READY: the read returns the old bank during the accept cycle. After the accept edge, `keys_valid = 0`, and `rk[1..NR]` contain stale values until they are rewritten.
- `rk_out` has zero-cycle read latency; it is purely combinational from `rk_idx` and the bank.

## Structure
- Package `aes_pkg` holds:
  - `AES_NR = 10`
  - `typedef logic [127:0] aes_block_t`
  - the FSM enum `ks_state_e {IDLE, EXPAND, READY}`
- Sub-module: one instance of the existing `key_expansion (num_round, key, out)` round function. It is the only combinational datapath; the controller adds only the FSM, the counter, the 11×128 register bank and the read mux.

## Test plan
- Reset check: hold `rst_n` low for 2 cycles. Required: `key_ready = 1`, `busy = 0`, `keys_valid = 0`, and `rk_out = 0` for every index.
- FIPS-197 vector: load `2b7e151628aed2a6abf7158809cf4f3c`, wait for `keys_valid`. Required:
  - `rk[1] = a0fafe1788542cb123a339392a6c7605`
  - `rk[2] = f2c295f27a96b9435935807a7359f67f`
  - `rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6`
  - `keys_valid` rises exactly 10 cycles after the accept edge
- Key during EXPAND: assert `key_valid` with a different key 3 cycles after accept. Required: `key_ready = 0`, the schedule is unaffected, and the second key is accepted on the first READY cycle.
- Back-to-back keys: accept key A, then key B in the first READY cycle. Required: `keys_valid` low for 10 cycles, then the bank equals B's schedule.
- Reset mid-EXPAND: pull `rst_n` low at round 5. Required: all outputs return to reset values the next cycle, and a fresh load then produces the correct FIPS-197 schedule.
- Out-of-range read: drive `rk_idx = 11..15` in READY. Required: `rk_out = 0`.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, block type, key-schedule FSM states
// and the GF(2^8) helpers behind the S-box used by the round function.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } ks_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] num_round);
        case (num_round)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/key_expansion.sv
// AES-128 key expansion round: derives round key num_round+1 from round key num_round.
module key_expansion
    import aes_pkg::*;
(
    input  logic [3:0] num_round,
    input  aes_block_t key,
    output aes_block_t out
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;

    // RotWord then SubWord on the last word, with the round constant on the leading byte.
    assign t = {sbox(w3[23:16]) ^ rcon(num_round), sbox(w3[15:8]),
                sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequences key_expansion to fill an (NR+1)-entry round-key bank, one key per
// clock, and serves the bank through a combinational indexed read port.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);
    localparam logic [3:0] LAST_RND = 4'(NR - 1);
    localparam logic [3:0] MAX_IDX  = 4'(NR);

    ks_state_e   state_reg;
    logic [3:0]  round_cnt_reg;
    logic        keys_valid_reg;
    aes_block_t  rk_reg [NR+1];
    aes_block_t  exp_key;
    logic        expanding;
    logic        accept;
    logic [NR:0] rk_we;

    assign expanding  = (state_reg == EXPAND);
    assign key_ready  = !expanding;
    assign busy       = expanding;
    assign keys_valid = keys_valid_reg;
    assign accept     = key_valid && key_ready;

    key_expansion u_key_expansion (
        .num_round (round_cnt_reg),
        .key       (rk_reg[round_cnt_reg]),
        .out       (exp_key)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            round_cnt_reg  <= '0;
            keys_valid_reg <= 1'b0;
        end else if (accept) begin
            state_reg      <= EXPAND;
            round_cnt_reg  <= '0;
            keys_valid_reg <= 1'b0;
        end else if (expanding) begin
            round_cnt_reg <= round_cnt_reg + 4'd1;
            if (round_cnt_reg == LAST_RND) begin
                state_reg      <= READY;
                keys_valid_reg <= 1'b1;
            end
        end
    end

    // Entry 0 takes the cipher key; entry n is written by expansion round n-1.
    for (genvar gi = 0; gi <= NR; gi++) begin : g_bank_we
        if (gi == 0) begin : g_key
            assign rk_we[gi] = accept;
        end else begin : g_round
            assign rk_we[gi] = expanding && (round_cnt_reg == 4'(gi - 1));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i <= NR; i++) begin
            if (!rst_n) begin
                rk_reg[i] <= '0;
            end else if (rk_we[i]) begin
                rk_reg[i] <= (i == 0) ? key_in : exp_key;
            end
        end
    end

    assign rk_out = (rk_idx <= MAX_IDX) ? rk_reg[rk_idx] : '0;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using the FIPS-197 and all-zero key schedules.
module tb_aes_key_sched_ctrl;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_idx = '0;
    logic [127:0] rk_out;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_keys_valid(output int cycles);
        cycles = 0;
        while (!keys_valid && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (key_ready !== 1'b1) begin miscompares++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL reset_keys_valid: got %b want 0", keys_valid); end
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            #1;
            vectors++;
            if (rk_out !== 128'h0) begin miscompares++; $display("FAIL reset_rk[%0d]: got %h want 0", i, rk_out); end
        end
        rst_n = 1'b1;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_fips();
        int c;
        accept_key(FIPS_KEY);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL fips_busy: got %b want 1", busy); end
        wait_keys_valid(c);
        vectors++;
        if (c != 10) begin miscompares++; $display("FAIL fips_latency: got %0d want 10", c); end
        vectors++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL fips_ready_state: got ready=%b busy=%b want 1 0", key_ready, busy); end
        for (int i = 0; i <= 10; i++) begin
            rk_idx = 4'(i);
            #1;
            vectors++;
            if (rk_out !== FIPS_RK[i]) begin miscompares++; $display("FAIL fips_rk[%0d]: got %h want %h", i, rk_out, FIPS_RK[i]); end
        end
        $display("test_fips: done");
    endtask

    task automatic test_key_during_expand();
        int c;
        accept_key(FIPS_KEY);
        tick();
        tick();
        tick();
        key_in    = '0;
        key_valid = 1'b1;
        #1;
        vectors++;
        if (key_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL kde_handshake: got ready=%b busy=%b want 0 1", key_ready, busy); end
        wait_keys_valid(c);
        vectors++;
        if (c != 7) begin miscompares++; $display("FAIL kde_latency: got %0d want 7", c); end
        rk_idx = 4'd1;
        #1;
        vectors++;
        if (rk_out !== FIPS_RK[1]) begin miscompares++; $display("FAIL kde_rk1: got %h want %h", rk_out, FIPS_RK[1]); end
        rk_idx = 4'd10;
        #1;
        vectors++;
        if (rk_out !== FIPS_RK[10]) begin miscompares++; $display("FAIL kde_rk10: got %h want %h", rk_out, FIPS_RK[10]); end
        tick();
        key_valid = 1'b0;
        vectors++;
        if (keys_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL kde_second_accept: got kv=%b busy=%b want 0 1", keys_valid, busy); end
        rk_idx = 4'd1;
        #1;
        vectors++;
        if (rk_out !== FIPS_RK[1]) begin miscompares++; $display("FAIL kde_stale_rk1: got %h want %h", rk_out, FIPS_RK[1]); end
        wait_keys_valid(c);
        vectors++;
        if (c != 10) begin miscompares++; $display("FAIL kde_second_latency: got %0d want 10", c); end
        rk_idx = 4'd2;
        #1;
        vectors++;
        if (rk_out !== ZERO_RK2) begin miscompares++; $display("FAIL kde_zero_rk2: got %h want %h", rk_out, ZERO_RK2); end
        rk_idx = 4'd10;
        #1;
        vectors++;
        if (rk_out !== ZERO_RK10) begin miscompares++; $display("FAIL kde_zero_rk10: got %h want %h", rk_out, ZERO_RK10); end
        $display("test_key_during_expand: done");
    endtask

    task automatic test_back_to_back();
        int c;
        accept_key(FIPS_KEY);
        wait_keys_valid(c);
        vectors++;
        if (c != 10) begin miscompares++; $display("FAIL b2b_a_latency: got %0d want 10", c); end
        key_in    = '0;
        key_valid = 1'b1;
        rk_idx    = 4'd10;
        #1;
        vectors++;
        if (rk_out !== FIPS_RK[10]) begin miscompares++; $display("FAIL b2b_old_bank_read: got %h want %h", rk_out, FIPS_RK[10]); end
        for (int i = 0; i <= 10; i++) begin
            tick();
            key_valid = 1'b0;
            vectors++;
            if (keys_valid !== (i == 10)) begin miscompares++; $display("FAIL b2b_keys_valid_e%0d: got %b want %b", i, keys_valid, (i == 10)); end
        end
        rk_idx = 4'd0;
        #1;
        vectors++;
        if (rk_out !== 128'h0) begin miscompares++; $display("FAIL b2b_rk0: got %h want 0", rk_out); end
        rk_idx = 4'd1;
        #1;
        vectors++;
        if (rk_out !== ZERO_RK1) begin miscompares++; $display("FAIL b2b_rk1: got %h want %h", rk_out, ZERO_RK1); end
        rk_idx = 4'd10;
        #1;
        vectors++;
        if (rk_out !== ZERO_RK10) begin miscompares++; $display("FAIL b2b_rk10: got %h want %h", rk_out, ZERO_RK10); end
        $display("test_back_to_back: done");
    endtask

    task automatic test_reset_mid_expand();
        int c;
        accept_key(FIPS_KEY);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_flags: got ready=%b busy=%b kv=%b want 1 0 0", key_ready, busy, keys_valid);
        end
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            #1;
            vectors++;
            if (rk_out !== 128'h0) begin miscompares++; $display("FAIL mid_reset_rk[%0d]: got %h want 0", i, rk_out); end
        end
        rst_n = 1'b1;
        tick();
        accept_key(FIPS_KEY);
        wait_keys_valid(c);
        vectors++;
        if (c != 10) begin miscompares++; $display("FAIL mid_reset_reload_latency: got %0d want 10", c); end
        for (int i = 0; i <= 10; i++) begin
            rk_idx = 4'(i);
            #1;
            vectors++;
            if (rk_out !== FIPS_RK[i]) begin miscompares++; $display("FAIL mid_reset_rk_reload[%0d]: got %h want %h", i, rk_out, FIPS_RK[i]); end
        end
        $display("test_reset_mid_expand: done");
    endtask

    task automatic test_out_of_range();
        rk_idx = 4'd10;
        #1;
        vectors++;
        if (rk_out !== FIPS_RK[10]) begin miscompares++; $display("FAIL oor_rk10: got %h want %h", rk_out, FIPS_RK[10]); end
        for (int i = 11; i < 16; i++) begin
            rk_idx = 4'(i);
            #1;
            vectors++;
            if (rk_out !== 128'h0) begin miscompares++; $display("FAIL oor_rk[%0d]: got %h want 0", i, rk_out); end
        end
        $display("test_out_of_range: done");
    endtask

    initial begin
        test_reset();
        test_fips();
        test_key_during_expand();
        test_back_to_back();
        test_reset_mid_expand();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
